// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding,
// coin select codes and the matching denomination values.
package change_dispenser_pkg;

  localparam int AMOUNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  localparam logic [AMOUNT_W-1:0] VAL_1  = 5'd1;
  localparam logic [AMOUNT_W-1:0] VAL_2  = 5'd2;
  localparam logic [AMOUNT_W-1:0] VAL_5  = 5'd5;
  localparam logic [AMOUNT_W-1:0] VAL_10 = 5'd10;

endpackage

// File: rtl/change_dispenser_if.sv
// Control and coin-handshake bundle of the change dispenser.
//   master : upstream stage + coin mechanism (drives start/amount/ack/clear)
//   slave  : change_dispenser (drives coin request and status)
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic                start;
  logic [AMOUNT_W-1:0] change_amount;
  logic                coin_ack;
  logic                fault_clear;
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                busy;
  logic                done;
  logic                fault;
  logic [AMOUNT_W-1:0] remaining;
  logic [2:0]          coins_paid;

  modport master (
    output start, change_amount, coin_ack, fault_clear,
    input  coin_valid, coin_sel, busy, done, fault, remaining, coins_paid
  );

  modport slave (
    input  start, change_amount, coin_ack, fault_clear,
    output coin_valid, coin_sel, busy, done, fault, remaining, coins_paid
  );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin choice: largest denomination not exceeding the amount owed.
//   remaining  in  amount still owed
//   coin_sel   out select code of the chosen coin
//   coin_value out NIS value of the chosen coin (never exceeds remaining
//                  when remaining != 0)
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
(
  input  logic [AMOUNT_W-1:0] remaining,
  output logic [1:0]          coin_sel,
  output logic [AMOUNT_W-1:0] coin_value
);

  always_comb begin
    coin_sel   = COIN_1;
    coin_value = VAL_1;
    if (remaining >= VAL_10) begin
      coin_sel   = COIN_10;
      coin_value = VAL_10;
    end else if (remaining >= VAL_5) begin
      coin_sel   = COIN_5;
      coin_value = VAL_5;
    end else if (remaining >= VAL_2) begin
      coin_sel   = COIN_2;
      coin_value = VAL_2;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out as coins, one per coin_ack, with a
// watchdog that parks in FAULT if the mechanism stops acknowledging.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : change_dispenser_if.slave (start/amount in, coin handshake,
//                busy/done/fault status, remaining and coins_paid)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; remaining reads 0
// ST_ISSUE | presenting coin_sel, waiting for coin_ack, watchdog running
// ST_DONE  | one-cycle done pulse, then back to IDLE
// ST_FAULT | watchdog expired; unpaid amount held until fault_clear
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TMR_W          = 4
) (
  input logic            clk,
  input logic            rst_n,
  change_dispenser_if.slave bus
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [AMOUNT_W-1:0] remaining_q;
  logic [2:0]          coins_paid_q;
  logic [TMR_W-1:0]    timer_q;
  logic [1:0]          sel;
  logic [AMOUNT_W-1:0] coin_value;

  // Selection runs off the registered amount so coin_sel is stable until ack.
  change_dispenser_coin_select u_coin_select (
    .remaining  (remaining_q),
    .coin_sel   (sel),
    .coin_value (coin_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start)
          state_d = (bus.change_amount == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.coin_ack) begin
          if (remaining_q == coin_value) state_d = ST_DONE;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: begin
        if (bus.fault_clear) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q  <= '0;
      coins_paid_q <= '0;
      timer_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            remaining_q  <= bus.change_amount;
            coins_paid_q <= '0;
            timer_q      <= '0;
          end
        end
        ST_ISSUE: begin
          if (bus.coin_ack) begin
            remaining_q  <= remaining_q - coin_value;
            coins_paid_q <= coins_paid_q + 3'd1;
            timer_q      <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_FAULT: begin
          // coins_paid stays visible after clear; only the debt is dropped.
          if (bus.fault_clear) remaining_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.coin_valid = (state_q == ST_ISSUE);
  assign bus.coin_sel   = (state_q == ST_ISSUE) ? sel : COIN_1;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.remaining  = remaining_q;
  assign bus.coins_paid = coins_paid_q;

endmodule
